mul_dispatch: RTL and testbench

- Initiator side of the MUL microcode handshake. It sits between the IF stage and the ID stage.
- Detects MULI/MULR/MULSI/MULSR in the fetched stream, stalls fetch, and launches the microcode sequencer with `start_mul` and the decoded operands.
- While the sequencer holds `ucode_mux_ctrl`, it forwards the sequencer's injected instructions to ID.
- On `mul_release` it restores flags, releases fetch and resumes normal pass-through.

---
 rtl/mul_dispatch_if.sv | 42 ++++
 rtl/mul_dispatch.sv | 167 ++++++++++++++++
 tb/tb_mul_dispatch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_dispatch_if.sv
// Bundle of the IF/ID/sequencer signals seen by the MUL dispatch block.
// The master side is the dispatcher. The slave side is its environment:
// the fetch stage, the microcode sequencer, EX flags and the ID stage.
interface mul_dispatch_if;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic [31:0] ucode_instr;
    logic        ucode_mux_ctrl;
    logic        mul_release;
    logic [3:0]  flags_restore;
    logic [3:0]  flags_exec;
    logic [31:0] instr_to_id;
    logic        instr_valid;
    logic        pc_stall;
    logic        start_mul;
    logic [3:0]  dest_reg;
    logic [3:0]  source_reg;
    logic [3:0]  rs2_addr;
    logic [15:0] immediate;
    logic [1:0]  mul_type;
    logic [3:0]  flags_snapshot;
    logic [3:0]  flags_out;
    logic        flags_restore_en;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  fetch_instr, fetch_valid, ucode_instr, ucode_mux_ctrl,
               mul_release, flags_restore, flags_exec,
        output instr_to_id, instr_valid, pc_stall, start_mul, dest_reg,
               source_reg, rs2_addr, immediate, mul_type, flags_snapshot,
               flags_out, flags_restore_en, busy, timeout_err
    );

    modport slave (
        output fetch_instr, fetch_valid, ucode_instr, ucode_mux_ctrl,
               mul_release, flags_restore, flags_exec,
        input  instr_to_id, instr_valid, pc_stall, start_mul, dest_reg,
               source_reg, rs2_addr, immediate, mul_type, flags_snapshot,
               flags_out, flags_restore_en, busy, timeout_err
    );
endinterface

// File: rtl/mul_dispatch.sv
// MUL dispatch: this block sits between IF and ID.
// It spots MUL opcodes in the fetch stream, stalls fetch and launches the
// microcode sequencer. While the sequencer runs, the block forwards the
// injected instructions to ID. On release, or on a watchdog timeout, it
// restores the flags and hands fetch back.
module mul_dispatch #(
    parameter logic [6:0] OP_MULI  = 7'b0010011,
    parameter logic [6:0] OP_MULR  = 7'b0110011,
    parameter logic [6:0] OP_MULSI = 7'b0011011,
    parameter logic [6:0] OP_MULSR = 7'b0111011,
    parameter int         WDOG_W   = 20
) (
    input  logic          clk,
    input  logic          rst,
    mul_dispatch_if.master bus
);

    localparam logic [31:0] NOP = {5'b11001, 27'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t             state;
    logic [3:0]         dest_q;
    logic [3:0]         src_q;
    logic [3:0]         rs2_q;
    logic [15:0]        imm_q;
    logic [1:0]         type_q;
    logic [3:0]         snap_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic               timeout_q;

    logic               mul_hit;
    logic [1:0]         type_dec;
    logic               wdog_sat;

    logic [31:0]        instr_to_id_c;
    logic               instr_valid_c;
    logic               pc_stall_c;
    logic               start_mul_c;
    logic [3:0]         flags_out_c;
    logic               flags_restore_en_c;
    logic               busy_c;

    assign wdog_sat = &wdog_q;

    // Decode the fetched opcode into a MUL hit and its type (bit 0 set = register form)
    always_comb begin
        mul_hit  = 1'b0;
        type_dec = 2'd0;
        case (bus.fetch_instr[31:25])
            OP_MULI:  begin mul_hit = bus.fetch_valid; type_dec = 2'd0; end
            OP_MULR:  begin mul_hit = bus.fetch_valid; type_dec = 2'd1; end
            OP_MULSI: begin mul_hit = bus.fetch_valid; type_dec = 2'd2; end
            OP_MULSR: begin mul_hit = bus.fetch_valid; type_dec = 2'd3; end
            default:  begin mul_hit = 1'b0; type_dec = 2'd0; end
        endcase
    end

    // State, operand latches, watchdog and sticky timeout error
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dest_q    <= '0;
            src_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            type_q    <= '0;
            snap_q    <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mul_hit) begin
                        dest_q <= bus.fetch_instr[24:21];
                        src_q  <= bus.fetch_instr[20:17];
                        rs2_q  <= bus.fetch_instr[16:13];
                        // Register forms carry a nonzero sentinel; the real count comes from rs2
                        imm_q  <= type_dec[0] ? 16'h0001 : bus.fetch_instr[15:0];
                        type_q <= type_dec;
                        snap_q <= bus.flags_exec;
                        state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog_q <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mul_release) begin
                        state <= S_IDLE;
                    end else if (wdog_sat) begin
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output mux: pass-through in IDLE, stall/launch, then forward or release
    always_comb begin
        instr_to_id_c      = NOP;
        instr_valid_c      = 1'b0;
        pc_stall_c         = 1'b0;
        start_mul_c        = 1'b0;
        flags_out_c        = snap_q;
        flags_restore_en_c = 1'b0;
        busy_c             = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (mul_hit) begin
                        pc_stall_c = 1'b1;
                    end else begin
                        instr_to_id_c = bus.fetch_instr;
                        instr_valid_c = bus.fetch_valid;
                    end
                end
                S_LAUNCH: begin
                    start_mul_c = 1'b1;
                    pc_stall_c  = 1'b1;
                    busy_c      = 1'b1;
                end
                S_WAIT: begin
                    busy_c     = 1'b1;
                    pc_stall_c = 1'b1;
                    if (bus.mul_release) begin
                        flags_out_c        = bus.flags_restore;
                        flags_restore_en_c = 1'b1;
                        pc_stall_c         = 1'b0;
                    end else if (wdog_sat) begin
                        flags_restore_en_c = 1'b1;
                        pc_stall_c         = 1'b0;
                    end else if (bus.ucode_mux_ctrl) begin
                        instr_to_id_c = bus.ucode_instr;
                        instr_valid_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_to_id      = instr_to_id_c;
    assign bus.instr_valid      = instr_valid_c;
    assign bus.pc_stall         = pc_stall_c;
    assign bus.start_mul        = start_mul_c;
    assign bus.flags_out        = flags_out_c;
    assign bus.flags_restore_en = flags_restore_en_c;
    assign bus.busy             = busy_c;
    assign bus.dest_reg         = dest_q;
    assign bus.source_reg       = src_q;
    assign bus.rs2_addr         = rs2_q;
    assign bus.immediate        = imm_q;
    assign bus.mul_type         = type_q;
    assign bus.flags_snapshot   = snap_q;
    assign bus.timeout_err      = timeout_q;

endmodule

// File: tb/tb_mul_dispatch.sv
// Directed bench for mul_dispatch. It uses a 4-bit watchdog, so timeout
// happens in the 16th WAIT cycle.
module tb_mul_dispatch;

    localparam logic [31:0] NOP   = 32'hC800_0000;
    localparam logic [31:0] ADD   = 32'h00A0_0000;
    localparam logic [31:0] SUB   = 32'h0AB0_1234;
    localparam logic [31:0] MULI1 = 32'h2620_0003;
    localparam logic [31:0] MULSR = 32'h7646_8000;
    localparam logic [31:0] MULSI = 32'h36AC_1234;
    localparam logic [31:0] MULR  = 32'h66E3_2000;

    logic clk;
    logic rst;
    int   compared    = 0;
    int   mismatched  = 0;
    int   start_count = 0;
    int   starts_before;

    mul_dispatch_if bus ();

    mul_dispatch #(.WDOG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count launch pulses so the bench can check back-to-back MULs
    always @(posedge clk) begin
        if (!rst && bus.start_mul) start_count++;
    end

    // Drive the inputs mid-cycle on the negedge, then let the combinational outputs settle
    task automatic applyStimulus(input logic r, input logic [31:0] fi, input logic fv,
                                 input logic [31:0] ui, input logic umc, input logic rel,
                                 input logic [3:0] fr, input logic [3:0] fe);
        @(negedge clk);
        rst                = r;
        bus.fetch_instr    = fi;
        bus.fetch_valid    = fv;
        bus.ucode_instr    = ui;
        bus.ucode_mux_ctrl = umc;
        bus.mul_release    = rel;
        bus.flags_restore  = fr;
        bus.flags_exec     = fe;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [31:0] useq [4];

    initial begin
        useq[0] = 32'h1111_0001; useq[1] = 32'h2222_0002;
        useq[2] = 32'h3333_0003; useq[3] = 32'h4444_0004;
        rst = 1'b1;
        bus.fetch_instr = '0; bus.fetch_valid = 1'b0; bus.ucode_instr = '0;
        bus.ucode_mux_ctrl = 1'b0; bus.mul_release = 1'b0;
        bus.flags_restore = '0; bus.flags_exec = '0;

        // Reset with a valid MUL on fetch: nothing may leak through
        applyStimulus(1, MULI1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, MULI1, 1, 0, 1, 1, 4'hF, 0);
        checkOutput("rst_instr",  bus.instr_to_id, NOP);
        checkOutput("rst_valid",  bus.instr_valid, 0);
        checkOutput("rst_stall",  bus.pc_stall, 0);
        checkOutput("rst_start",  bus.start_mul, 0);
        checkOutput("rst_busy",   bus.busy, 0);
        checkOutput("rst_fren",   bus.flags_restore_en, 0);

        // Plain pass-through; release/ucode in IDLE are ignored
        applyStimulus(0, ADD, 1, 0, 0, 0, 0, 0);
        checkOutput("add_instr",  bus.instr_to_id, ADD);
        checkOutput("add_valid",  bus.instr_valid, 1);
        checkOutput("add_stall",  bus.pc_stall, 0);
        checkOutput("add_busy",   bus.busy, 0);
        checkOutput("post_dest",  bus.dest_reg, 0);
        checkOutput("post_imm",   bus.immediate, 0);
        checkOutput("post_tmo",   bus.timeout_err, 0);
        applyStimulus(0, SUB, 1, 32'h55, 1, 1, 4'hF, 0);
        checkOutput("sub_instr",  bus.instr_to_id, SUB);
        checkOutput("sub_valid",  bus.instr_valid, 1);
        checkOutput("sub_fren",   bus.flags_restore_en, 0);
        checkOutput("sub_start",  bus.start_mul, 0);
        // MUL opcode without fetch_valid is not a MUL
        applyStimulus(0, MULI1, 0, 0, 0, 0, 0, 0);
        checkOutput("nv_stall",   bus.pc_stall, 0);
        checkOutput("nv_valid",   bus.instr_valid, 0);
        checkOutput("nv_instr",   bus.instr_to_id, MULI1);

        // MULI R1,R0,#3: detect, launch, four injected instructions, release
        applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 4'b0101);
        checkOutput("muli_det_stall", bus.pc_stall, 1);
        checkOutput("muli_det_valid", bus.instr_valid, 0);
        checkOutput("muli_det_instr", bus.instr_to_id, NOP);
        checkOutput("muli_det_start", bus.start_mul, 0);
        applyStimulus(0, MULI1, 1, 32'h77, 1, 1, 4'hF, 0);
        checkOutput("muli_l_start", bus.start_mul, 1);
        checkOutput("muli_l_stall", bus.pc_stall, 1);
        checkOutput("muli_l_busy",  bus.busy, 1);
        checkOutput("muli_l_valid", bus.instr_valid, 0);
        checkOutput("muli_l_fren",  bus.flags_restore_en, 0);
        checkOutput("muli_l_dest",  bus.dest_reg, 1);
        checkOutput("muli_l_src",   bus.source_reg, 0);
        checkOutput("muli_l_imm",   bus.immediate, 3);
        checkOutput("muli_l_type",  bus.mul_type, 0);
        checkOutput("muli_l_snap",  bus.flags_snapshot, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, MULI1, 1, useq[i], 1, 0, 0, 0);
            checkOutput("muli_u_instr", bus.instr_to_id, useq[i]);
            checkOutput("muli_u_valid", bus.instr_valid, 1);
            checkOutput("muli_u_stall", bus.pc_stall, 1);
            checkOutput("muli_u_start", bus.start_mul, 0);
            checkOutput("muli_u_imm",   bus.immediate, 3);
        end
        applyStimulus(0, MULI1, 1, 32'h99, 0, 0, 0, 0);
        checkOutput("muli_gap_instr", bus.instr_to_id, NOP);
        checkOutput("muli_gap_valid", bus.instr_valid, 0);
        applyStimulus(0, MULI1, 1, 32'h2222, 1, 1, 4'b1100, 0);
        checkOutput("muli_r_fren",  bus.flags_restore_en, 1);
        checkOutput("muli_r_flags", bus.flags_out, 4'b1100);
        checkOutput("muli_r_stall", bus.pc_stall, 0);
        checkOutput("muli_r_valid", bus.instr_valid, 0);
        checkOutput("muli_r_instr", bus.instr_to_id, NOP);
        applyStimulus(0, ADD, 1, 0, 0, 0, 0, 0);
        checkOutput("after_instr", bus.instr_to_id, ADD);
        checkOutput("after_busy",  bus.busy, 0);
        checkOutput("after_fren",  bus.flags_restore_en, 0);

        // MULSR then MULSI back to back; MULSI release collides with watchdog saturation
        starts_before = start_count;
        applyStimulus(0, MULSR, 1, 0, 0, 0, 0, 4'b1010);
        checkOutput("mulsr_det_stall", bus.pc_stall, 1);
        applyStimulus(0, MULSR, 1, 0, 0, 0, 0, 0);
        checkOutput("mulsr_start", bus.start_mul, 1);
        checkOutput("mulsr_type",  bus.mul_type, 3);
        checkOutput("mulsr_rs2",   bus.rs2_addr, 4);
        checkOutput("mulsr_imm",   bus.immediate, 16'h0001);
        checkOutput("mulsr_dest",  bus.dest_reg, 2);
        checkOutput("mulsr_src",   bus.source_reg, 3);
        checkOutput("mulsr_snap",  bus.flags_snapshot, 4'b1010);
        applyStimulus(0, MULSR, 1, 0, 0, 0, 0, 0);
        checkOutput("mulsr_w_busy", bus.busy, 1);
        checkOutput("mulsr_w_fren", bus.flags_restore_en, 0);
        applyStimulus(0, MULSR, 1, 0, 0, 1, 4'b0110, 0);
        checkOutput("mulsr_r_flags", bus.flags_out, 4'b0110);
        checkOutput("mulsr_r_fren",  bus.flags_restore_en, 1);
        checkOutput("mulsr_r_stall", bus.pc_stall, 0);
        applyStimulus(0, MULSI, 1, 0, 0, 0, 0, 4'b0011);
        checkOutput("mulsi_det_stall", bus.pc_stall, 1);
        checkOutput("mulsi_det_start", bus.start_mul, 0);
        applyStimulus(0, MULSI, 1, 0, 0, 0, 0, 0);
        checkOutput("mulsi_start", bus.start_mul, 1);
        checkOutput("mulsi_type",  bus.mul_type, 2);
        checkOutput("mulsi_dest",  bus.dest_reg, 5);
        checkOutput("mulsi_src",   bus.source_reg, 6);
        checkOutput("mulsi_imm",   bus.immediate, 16'h1234);
        checkOutput("mulsi_rs2",   bus.rs2_addr, 0);
        checkOutput("mulsi_snap",  bus.flags_snapshot, 4'b0011);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, MULSI, 1, 0, 0, 0, 0, 0);
            checkOutput("mulsi_w_stall", bus.pc_stall, 1);
            checkOutput("mulsi_w_fren",  bus.flags_restore_en, 0);
        end
        applyStimulus(0, MULSI, 1, 0, 0, 1, 4'b1001, 0);
        checkOutput("sat_rel_flags", bus.flags_out, 4'b1001);
        checkOutput("sat_rel_fren",  bus.flags_restore_en, 1);
        checkOutput("sat_rel_stall", bus.pc_stall, 0);
        applyStimulus(0, ADD, 1, 0, 0, 0, 0, 0);
        checkOutput("sat_rel_tmo",  bus.timeout_err, 0);
        checkOutput("sat_rel_busy", bus.busy, 0);
        checkOutput("two_starts",   start_count - starts_before, 2);

        // Watchdog expiry with no release
        applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 4'b0111);
        applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 0);
        checkOutput("wd_start", bus.start_mul, 1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 0);
            checkOutput("wd_w_stall", bus.pc_stall, 1);
        end
        applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 0);
        checkOutput("wd_fren",  bus.flags_restore_en, 1);
        checkOutput("wd_flags", bus.flags_out, 4'b0111);
        checkOutput("wd_stall", bus.pc_stall, 0);
        checkOutput("wd_valid", bus.instr_valid, 0);
        applyStimulus(0, ADD, 1, 0, 0, 0, 0, 0);
        checkOutput("wd_tmo",   bus.timeout_err, 1);
        checkOutput("wd_busy",  bus.busy, 0);
        checkOutput("wd_instr", bus.instr_to_id, ADD);
        applyStimulus(0, SUB, 1, 0, 0, 0, 0, 0);
        checkOutput("wd_sticky", bus.timeout_err, 1);

        // Reset while waiting aborts with no flag restore; a later MULR launches normally
        applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, MULI1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, MULI1, 1, 32'h33, 1, 0, 0, 0);
        checkOutput("rw_fwd", bus.instr_to_id, 32'h33);
        applyStimulus(1, MULI1, 1, 32'h44, 1, 1, 4'hF, 0);
        checkOutput("rw_instr", bus.instr_to_id, NOP);
        checkOutput("rw_valid", bus.instr_valid, 0);
        checkOutput("rw_stall", bus.pc_stall, 0);
        checkOutput("rw_fren",  bus.flags_restore_en, 0);
        applyStimulus(0, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("rw_post_instr", bus.instr_to_id, NOP);
        checkOutput("rw_post_stall", bus.pc_stall, 0);
        checkOutput("rw_post_busy",  bus.busy, 0);
        checkOutput("rw_post_tmo",   bus.timeout_err, 0);
        applyStimulus(0, MULR, 1, 0, 0, 0, 0, 4'b1111);
        checkOutput("mulr_det_stall", bus.pc_stall, 1);
        applyStimulus(0, MULR, 1, 0, 0, 0, 0, 0);
        checkOutput("mulr_start", bus.start_mul, 1);
        checkOutput("mulr_type",  bus.mul_type, 1);
        checkOutput("mulr_rs2",   bus.rs2_addr, 9);
        checkOutput("mulr_imm",   bus.immediate, 16'h0001);
        checkOutput("mulr_dest",  bus.dest_reg, 7);
        checkOutput("mulr_src",   bus.source_reg, 1);
        checkOutput("mulr_snap",  bus.flags_snapshot, 4'b1111);
        applyStimulus(0, MULR, 1, 0, 0, 1, 4'b0001, 0);
        checkOutput("mulr_r_fren",  bus.flags_restore_en, 1);
        checkOutput("mulr_r_flags", bus.flags_out, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
